led_seq_ctrl: RTL and testbench

- Controller for the 8-bit one-hot LED pattern register.
- Conditions the raw push-button and toggles run/pause on each debounced press.
- Generates a prescaled step tick and sequences the pattern in one of four modes: rotate left, rotate right, ping-pong, or hold.
- Sits between the board button/mode switches and the LED pins.

---
 rtl/led_ctrl_pkg.sv | 18 +
 rtl/led_seq_ctrl_debounce.sv | 47 ++++
 rtl/led_seq_ctrl.sv | 103 ++++++++++
 tb/tb_led_seq_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED sequencer: pattern modes, ping-pong direction
// and the run/pause state type.
package led_ctrl_pkg;

  localparam logic [1:0] MODE_ROL  = 2'b00;
  localparam logic [1:0] MODE_ROR  = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic {
    PAUSED = 1'b0,
    RUN    = 1'b1
  } run_state_t;

endpackage

// File: rtl/led_seq_ctrl_debounce.sv
// Push-button conditioning: two-flop synchronizer, stability counter and
// a same-cycle strobe for the debounced 0->1 transition.
module button_debounce #(
  parameter int DB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          accept;

  // The level flips on the edge closing this cycle, so the strobe lines up
  // with the debounced level change rather than trailing it by a cycle.
  assign accept     = (s2 != level_out) && (cnt == CW'(DB_CYCLES - 1));
  assign rise_pulse = accept && s2;

  // NOTE: non-blocking assignments make s2 take the previous s1; blocking
  // ones here would collapse the synchronizer into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      cnt       <= '0;
      level_out <= 1'b0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
      if (s2 == level_out) begin
        cnt <= '0;
      end else if (accept) begin
        level_out <= s2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: run/pause toggled by debounced presses, prescaled
// step tick, and rotate-left / rotate-right / ping-pong / hold patterns.
module led_seq_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int DB_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic             running,
  output logic             tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  run_state_t       state;
  run_state_t       state_next;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_next;
  logic             dir;
  logic             dir_next;
  logic [WIDTH-1:0] led_next;
  logic [WIDTH-1:0] led_rol;
  logic [WIDTH-1:0] led_ror;
  logic             btn_level;
  logic             btn_rise;
  logic             press;

  button_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (button),
    .level_out  (btn_level),
    .rise_pulse (btn_rise)
  );

  assign press   = btn_rise && !btn_level;
  assign running = (state == RUN);
  assign tick    = running && (presc == PW'(DIV - 1));
  assign led_rol = {led[WIDTH-2:0], led[WIDTH-1]};
  assign led_ror = {led[0], led[WIDTH-1:1]};

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    presc_next = '0;
    led_next   = led;
    dir_next   = dir;

    if (press) begin
      state_next = (state == RUN) ? PAUSED : RUN;
    end

    // Counting only while staying in RUN keeps the prescaler at zero on the
    // resume edge, so the first step lands DIV edges after running rises.
    if (state == RUN && state_next == RUN) begin
      presc_next = tick ? '0 : presc + PW'(1);
    end

    if (tick) begin
      unique case (mode)
        MODE_ROL: led_next = led_rol;
        MODE_ROR: led_next = led_ror;
        MODE_PING: begin
          if (dir == DIR_LEFT && led[WIDTH-1]) begin
            dir_next = DIR_RIGHT;
            led_next = led_ror;
          end else if (dir == DIR_RIGHT && led[0]) begin
            dir_next = DIR_LEFT;
            led_next = led_rol;
          end else begin
            led_next = (dir == DIR_LEFT) ? led_rol : led_ror;
          end
        end
        MODE_HOLD: led_next = led;
        default:   led_next = led;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PAUSED;
      presc <= '0;
      led   <= WIDTH'(1);
      dir   <= DIR_LEFT;
    end else begin
      state <= state_next;
      presc <= presc_next;
      led   <= led_next;
      dir   <= dir_next;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed scenarios plus random button
// and mode activity, compared every cycle against a lit-position model.
module tb_led_seq_ctrl;

  localparam int W  = 8;
  localparam int DV = 4;
  localparam int DB = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         button;
  logic [1:0]   mode;
  logic [W-1:0] led;
  logic         running;
  logic         tick;

  int tests = 0;
  int fails = 0;

  led_seq_ctrl #(.WIDTH(W), .DIV(DV), .DB_CYCLES(DB)) dut (
    .clk     (clk),
    .rst     (rst),
    .button  (button),
    .mode    (mode),
    .led     (led),
    .running (running),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  // Reference model: the lit LED is an index, the pattern is 1 << index,
  // and stepping happens every DV-th cycle counted from the resume edge.
  int m_pos;
  bit m_right;
  bit m_run;
  int m_phase;
  bit m_q1, m_q2;
  bit m_level;
  int m_streak;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_right = 0; m_run = 0; m_phase = 0;
    m_q1 = 0; m_q2 = 0; m_level = 0; m_streak = 0;
  endtask

  function automatic bit model_tick();
    return m_run && (m_phase == DV - 1);
  endfunction

  task automatic model_edge(bit b, logic [1:0] md);
    bit stepping = model_tick();
    bit pressed  = 0;
    if (m_q2 != m_level) begin
      if (m_streak + 1 >= DB) begin
        pressed  = m_q2;
        m_level  = m_q2;
        m_streak = 0;
      end else begin
        m_streak++;
      end
    end else begin
      m_streak = 0;
    end
    if (stepping) begin
      case (md)
        2'd0: m_pos = (m_pos + 1) % W;
        2'd1: m_pos = (m_pos + W - 1) % W;
        2'd2: begin
          if (!m_right && m_pos == W - 1) begin m_right = 1; m_pos--; end
          else if (m_right && m_pos == 0) begin m_right = 0; m_pos++; end
          else m_pos = m_right ? m_pos - 1 : m_pos + 1;
        end
        default: ;
      endcase
    end
    m_phase = (m_run && !pressed) ? (m_phase + 1) % DV : 0;
    if (pressed) m_run = !m_run;
    m_q2 = m_q1;
    m_q1 = b;
  endtask

  task automatic cyc();
    logic [W-1:0] exp_led;
    @(posedge clk);
    model_edge(button, mode);
    @(negedge clk);
    exp_led = W'(1) << m_pos;
    check("led", led, exp_led);
    check("running", running, m_run);
    check("tick", tick, model_tick());
  endtask

  task automatic press(output int n);
    logic start = running;
    bit   done  = 0;
    button = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      cyc();
      n++;
      if (running !== start) done = 1;
    end
    check("press_toggle_timeout", done, 1);
    button = 1'b0;
  endtask

  task automatic wait_change(output logic [W-1:0] v, output int k);
    logic [W-1:0] prev = led;
    bit           seen = 0;
    k = 0;
    for (int i = 0; i < 3 * DV && !seen; i++) begin
      cyc();
      k++;
      if (led !== prev) seen = 1;
    end
    check("step_timeout", seen, 1);
    v = led;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("areset_led", led, 1);
    check("areset_running", running, 0);
    check("areset_tick", tick, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] frozen;
    logic [W-1:0] ping_exp [9];
    int n, k, tcnt;

    ping_exp = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    rst = 1'b1; button = 1'b0; mode = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_led", led, 1);
    check("reset_running", running, 0);
    check("reset_tick", tick, 0);
    repeat (20) cyc();
    check("idle_led", led, 1);
    check("idle_running", running, 0);

    // Glitch shorter than the debounce window
    button = 1'b1;
    repeat (2) cyc();
    button = 1'b0;
    repeat (10) cyc();
    check("glitch_running", running, 0);
    check("glitch_led", led, 1);

    // First press, rotate-left
    press(n);
    check("press_latency", n, DB + 2);
    check("press_running", running, 1);
    wait_change(v, k);
    check("first_step_delay", k, DV);
    check("rol_step1", v, 8'h02);
    wait_change(v, k);
    check("rol_step2", v, 8'h04);
    check("rol_spacing", k, DV);
    tcnt = 0;
    repeat (6 * DV) begin
      cyc();
      tcnt += int'(tick);
    end
    check("tick_count", tcnt, 6);
    check("rol_wrap", led, 8'h01);

    // Rotate-right from 0x01
    mode = 2'b01;
    wait_change(v, k); check("ror_step1", v, 8'h80);
    wait_change(v, k); check("ror_step2", v, 8'h40);
    wait_change(v, k); check("ror_step3", v, 8'h20);

    // Ping-pong starting at 0x40, dir still LEFT
    mode = 2'b00;
    wait_change(v, k); check("rol_to_40", v, 8'h40);
    mode = 2'b10;
    for (int i = 0; i < 9; i++) begin
      wait_change(v, k);
      check($sformatf("ping_%0d", i), v, ping_exp[i]);
    end

    // Hold keeps the pattern while the prescaler runs
    mode = 2'b11;
    frozen = led;
    repeat (3 * DV) cyc();
    check("hold_led", led, frozen);

    // Pause, then resume
    mode = 2'b00;
    press(n);
    check("pause_latency", n, DB + 2);
    check("pause_running", running, 0);
    frozen = led;
    repeat (12) cyc();
    check("paused_led", led, frozen);
    press(n);
    check("resume_running", running, 1);
    wait_change(v, k);
    check("resume_step_delay", k, DV);
    repeat (3) cyc();
    async_reset();

    // Random button noise and mode changes
    for (int s = 0; s < 120; s++) begin
      button = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 7)) cyc();
    end
    async_reset();
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
